// File: rtl/cpu55_mem_pkg.sv
// cpu55_mem_pkg: size, exception and LSU state encodings shared by the data_ram wrappers
package cpu55_mem_pkg;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILL} size_e;
  typedef enum logic [1:0] {EXC_NONE, EXC_ALIGN, EXC_RANGE, EXC_SIZE} exc_e;
  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_e;
endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: EX->LSU request and LSU->WB response handshakes
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [4:0]  rsp_rd;
  logic        rsp_load;
  logic [1:0]  rsp_exc;
  logic [31:0] rsp_addr;
  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, req_rd, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_rd, rsp_load, rsp_exc, rsp_addr
  );
  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, req_rd, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_rd, rsp_load, rsp_exc, rsp_addr
  );
endinterface

// File: rtl/lsu_addr_check.sv
// lsu_addr_check: prioritised size/alignment/range check of a memory access
module lsu_addr_check
  import cpu55_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 11
) (
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  output exc_e        exc
);
  always_comb
    exc = size == SZ_ILL ? EXC_SIZE :
          (size == SZ_HALF && addr[0]) || (size == SZ_WORD && addr[1:0] != 2'b00) ? EXC_ALIGN :
          (addr >> ADDR_WIDTH) != 32'd0 ? EXC_RANGE : EXC_NONE;
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding memory-stage load/store unit driving data_ram
module load_store_unit
  import cpu55_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  load_store_unit_if.slave      bus,
  output logic                  ram_ena,
  output logic                  wena,
  output logic                  w,
  output logic                  h,
  output logic                  b,
  output logic                  z,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [31:0]           data_in,
  input  logic [31:0]           ram_rdata,
  input  logic                  ram_aerr
);
  state_e state;
  exc_e   chk_exc;
  lsu_addr_check #(.ADDR_WIDTH(ADDR_WIDTH)) u_chk (
    .size(bus.req_size),
    .addr(bus.req_addr),
    .exc (chk_exc)
  );
  // RAM controls are flops with async clear so reset kills an in-progress store before its edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_rd    <= '0;
      bus.rsp_load  <= 1'b0;
      bus.rsp_exc   <= EXC_NONE;
      bus.rsp_addr  <= '0;
      {ram_ena, wena, w, h, b, z} <= '0;
      addr          <= '0;
      data_in       <= '0;
    end else begin
      case (state)
        IDLE: if (bus.req_valid) begin
          bus.req_ready <= 1'b0;
          bus.rsp_rd    <= bus.req_rd;
          bus.rsp_load  <= ~bus.req_we;
          bus.rsp_addr  <= bus.req_addr;
          bus.rsp_exc   <= chk_exc;
          bus.rsp_rdata <= '0;
          if (chk_exc != EXC_NONE) begin
            state         <= RESP;
            bus.rsp_valid <= 1'b1;
          end else begin
            state   <= ACCESS;
            ram_ena <= 1'b1;
            wena    <= bus.req_we;
            w       <= bus.req_size == SZ_WORD;
            h       <= bus.req_size == SZ_HALF;
            b       <= bus.req_size == SZ_BYTE;
            z       <= bus.req_unsigned;
            addr    <= bus.req_addr[ADDR_WIDTH-1:0];
            data_in <= bus.req_wdata;
          end
        end
        ACCESS: begin
          {ram_ena, wena, w, h, b, z} <= '0;
          addr          <= '0;
          data_in       <= '0;
          if (ram_aerr) bus.rsp_exc <= EXC_RANGE;
          state         <= wena ? RESP : CAPTURE;
          bus.rsp_valid <= wena;
        end
        CAPTURE: begin
          bus.rsp_rdata <= bus.rsp_exc == EXC_NONE ? ram_rdata : '0;
          bus.rsp_valid <= 1'b1;
          state         <= RESP;
        end
        RESP: if (bus.rsp_ready) begin
          bus.rsp_valid <= 1'b0;
          bus.req_ready <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed + random check of load_store_unit against a byte-array reference
module tb_load_store_unit;
  import cpu55_mem_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic        ram_ena, wena, w, h, b, z;
  logic [10:0] addr;
  logic [31:0] data_in;
  logic [31:0] ram_rdata = '0;
  logic        ram_aerr;
  logic        aerr_inj = 1'b0;
  logic [7:0]  mem [2048];
  logic [7:0]  ref_mem [2048];
  int vectors = 0;
  int miscompares = 0;
  load_store_unit_if bus();
  load_store_unit #(.ADDR_WIDTH(11)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .ram_ena  (ram_ena),
    .wena     (wena),
    .w        (w),
    .h        (h),
    .b        (b),
    .z        (z),
    .addr     (addr),
    .data_in  (data_in),
    .ram_rdata(ram_rdata),
    .ram_aerr (ram_aerr)
  );
  assign ram_aerr = aerr_inj & ram_ena;
  // data_ram model: little-endian bytes, registered read, extension done in the RAM
  always @(posedge clk) begin
    if (ram_ena && !ram_aerr) begin
      if (wena) begin
        mem[addr] <= data_in[7:0];
        if (h | w) mem[addr + 11'd1] <= data_in[15:8];
        if (w) begin
          mem[addr + 11'd2] <= data_in[23:16];
          mem[addr + 11'd3] <= data_in[31:24];
        end
      end else begin
        ram_rdata <= b ? {{24{~z & mem[addr][7]}}, mem[addr]} :
                     h ? {{16{~z & mem[addr + 11'd1][7]}}, mem[addr + 11'd1], mem[addr]} :
                         {mem[addr + 11'd3], mem[addr + 11'd2], mem[addr + 11'd1], mem[addr]};
      end
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic int nbytes(input logic [1:0] sz);
    return sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
  endfunction
  function automatic logic [1:0] ref_exc(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd3) return 2'd3;
    if (sz != 2'd0 && (a % nbytes(sz)) != 0) return 2'd1;
    if (a >= 32'd2048) return 2'd2;
    return 2'd0;
  endfunction
  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input logic uns);
    int n = nbytes(sz);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v |= 32'(ref_mem[int'(a[10:0]) + i]) << (8 * i);
    if (!uns && n < 4 && v[8 * n - 1]) v |= ~((32'd1 << (8 * n)) - 32'd1);
    return v;
  endfunction
  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] a,
                        input logic [31:0] wd, input logic [4:0] rd, input logic aerr,
                        input int stall, input logic keep);
    int lat = 1;
    int ena_cnt = 0;
    logic [1:0] e0, e;
    logic [31:0] exp_data, s_rdata, s_addr;
    logic [1:0] s_exc;
    e0 = ref_exc(sz, a);
    e = (e0 == 2'd0 && aerr) ? 2'd2 : e0;
    exp_data = (!we && e == 2'd0) ? ref_load(a, sz, uns) : 32'd0;
    if (we && e == 2'd0)
      for (int i = 0; i < nbytes(sz); i++) ref_mem[int'(a[10:0]) + i] = 8'(wd >> (8 * i));
    chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
    bus.req_we = we; bus.req_size = sz; bus.req_unsigned = uns; bus.req_addr = a;
    bus.req_wdata = wd; bus.req_rd = rd; bus.req_valid = 1'b1; bus.rsp_ready = 1'b0;
    aerr_inj = aerr;
    @(posedge clk);
    @(negedge clk);
    if (!keep) bus.req_valid = 1'b0;
    while (!bus.rsp_valid && lat < 8) begin
      if (ram_ena) begin
        ena_cnt++;
        chk("wena", 32'(wena), 32'(we));
        chk("whb", 32'({w, h, b}), sz == 2'd2 ? 32'd4 : sz == 2'd1 ? 32'd2 : 32'd1);
        chk("z", 32'(z), 32'(uns));
        chk("ram_addr", 32'(addr), 32'(a[10:0]));
        chk("data_in", data_in, wd);
      end
      chk("req_ready_busy", 32'(bus.req_ready), 32'd0);
      @(negedge clk);
      lat++;
    end
    aerr_inj = 1'b0;
    chk("latency", 32'(lat), e0 != 2'd0 ? 32'd1 : we ? 32'd2 : 32'd3);
    if (!bus.rsp_valid) return;
    chk("ram_ena_cycles", 32'(ena_cnt), e0 == 2'd0 ? 32'd1 : 32'd0);
    chk("rsp_rdata", bus.rsp_rdata, exp_data);
    chk("rsp_exc", 32'(bus.rsp_exc), 32'(e));
    chk("rsp_addr", bus.rsp_addr, a);
    chk("rsp_rd", 32'(bus.rsp_rd), 32'(rd));
    chk("rsp_load", 32'(bus.rsp_load), 32'(!we));
    s_rdata = bus.rsp_rdata; s_addr = bus.rsp_addr; s_exc = bus.rsp_exc;
    repeat (stall) begin
      @(negedge clk);
      chk("stall_valid", 32'(bus.rsp_valid), 32'd1);
      chk("stall_req_ready", 32'(bus.req_ready), 32'd0);
      chk("stall_rdata", bus.rsp_rdata, s_rdata);
      chk("stall_exc", 32'(bus.rsp_exc), 32'(s_exc));
      chk("stall_addr", bus.rsp_addr, s_addr);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b0;
    chk("rsp_valid_drop", 32'(bus.rsp_valid), 32'd0);
    chk("req_ready_back", 32'(bus.req_ready), 32'd1);
  endtask
  initial begin
    logic [1:0] sz;
    logic [31:0] a;
    for (int i = 0; i < 2048; i++) begin
      mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0; bus.req_unsigned = 1'b0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.req_rd = '0; bus.rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_req_ready", 32'(bus.req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset_ram_ena", 32'(ram_ena), 32'd0);
    chk("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    do_req(1'b1, 2'd2, 1'b0, 32'd0, 32'hffff0000, 5'd1, 1'b0, 0, 1'b0);
    do_req(1'b0, 2'd2, 1'b0, 32'd0, 32'd0, 5'd2, 1'b0, 0, 1'b0);
    do_req(1'b1, 2'd1, 1'b0, 32'd4, 32'h0000ffff, 5'd3, 1'b0, 0, 1'b0);
    do_req(1'b0, 2'd1, 1'b1, 32'd4, 32'd0, 5'd4, 1'b0, 0, 1'b0);
    do_req(1'b0, 2'd1, 1'b0, 32'd4, 32'd0, 5'd5, 1'b0, 0, 1'b0);
    do_req(1'b0, 2'd1, 1'b0, 32'd7, 32'd0, 5'd6, 1'b0, 0, 1'b0);
    do_req(1'b0, 2'd2, 1'b0, 32'h00000800, 32'd0, 5'd7, 1'b0, 0, 1'b0);
    do_req(1'b0, 2'd3, 1'b0, 32'd0, 32'd0, 5'd8, 1'b0, 0, 1'b0);
    do_req(1'b1, 2'd0, 1'b0, 32'd9, 32'h000000a5, 5'd9, 1'b0, 5, 1'b1);
    do_req(1'b0, 2'd0, 1'b0, 32'd9, 32'd0, 5'd10, 1'b0, 0, 1'b0);
    do_req(1'b0, 2'd2, 1'b0, 32'd0, 32'd0, 5'd11, 1'b1, 1, 1'b0);
    do_req(1'b1, 2'd2, 1'b0, 32'd0, 32'h12121212, 5'd12, 1'b1, 0, 1'b0);
    do_req(1'b0, 2'd2, 1'b0, 32'd0, 32'd0, 5'd13, 1'b0, 0, 1'b0);
    do_req(1'b1, 2'd2, 1'b0, 32'd8, 32'h12345678, 5'd14, 1'b0, 0, 1'b0);
    // reset lands mid-ACCESS of a store that must not commit
    bus.req_we = 1'b1; bus.req_size = 2'd2; bus.req_unsigned = 1'b0; bus.req_addr = 32'd8;
    bus.req_wdata = 32'hdeadbeef; bus.req_rd = 5'd15; bus.req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("rst_pre_ram_ena", 32'(ram_ena), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_ram_ena", 32'(ram_ena), 32'd0);
    chk("rst_wena", 32'(wena), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
    do_req(1'b0, 2'd2, 1'b0, 32'd8, 32'd0, 5'd16, 1'b0, 0, 1'b0);
    for (int n = 0; n < 60; n++) begin
      sz = $urandom_range(0, 9) == 0 ? 2'd3 : 2'($urandom_range(0, 2));
      a = $urandom_range(0, 2047);
      if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~32'(nbytes(sz) - 1);
      if ($urandom_range(0, 9) == 0) a = a | ($urandom & 32'hfffff800) | 32'h00000800;
      do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
             5'($urandom_range(0, 31)), $urandom_range(0, 7) == 0, $urandom_range(0, 3), 1'b0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage load/store unit of the cpu55 datapath, sitting directly upstream of `data_ram`. Accepts one load/store request at a time from the EX stage over a valid/ready handshake. Performs alignment and range checks, then drives the `data_ram` port set (`ram_ena`, `wena`, `w`, `h`, `b`, `z`, `addr`, `data_in`). Returns load data or an exception code to the WB side over a second valid/ready handshake.

## Interface
- `ADDR_WIDTH`, default 11: byte-address width of the attached `data_ram`.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `req_valid` / `req_ready`  in / out  1  EX→LSU handshake.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- `req_unsigned`  in  1  zero-extend load (drives `z`).
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data (right-justified).
- `req_rd`  in  5  destination register tag, returned unchanged.
- `ram_ena`, `wena`, `w`, `h`, `b`, `z`  out  1 each  `data_ram` controls.
- `addr`  out  `ADDR_WIDTH`  `data_ram` byte address.
- `data_in`  out  32  store data to `data_ram`.
- `ram_rdata`  in  32  `data_ram` `data_out` (already extended by the RAM).
- `ram_aerr`  in  1  `data_ram` `AddressError`.
- `rsp_valid` / `rsp_ready`  out / in  1  LSU→WB handshake.
- `rsp_rdata`  out  32  load result; 0 for stores and exceptions.
- `rsp_rd`  out  5  tag.
- `rsp_load`  out  1  1 = response is a load.
- `rsp_exc`  out  2  00 = none, 01 = misaligned, 10 = out-of-range, 11 = illegal size.
- `rsp_addr`  out  32  request address (bad address on exception).

## Operation
- FSM states: IDLE, ACCESS, CAPTURE, RESP.
- IDLE: `req_ready` = 1. A transfer occurs on `req_valid & req_ready`; the request is latched and checked in this order:
  - `req_size` = 11 → exc 11.
  - Misaligned (half: `addr[0]` ≠ 0; word: `addr[1:0]` ≠ 0) → exc 01.
  - `req_addr[31:ADDR_WIDTH]` ≠ 0 → exc 10.
- Any exception → RESP directly; no RAM access.
- No exception → ACCESS.
- ACCESS: drives `ram_ena` = 1, `wena` = `req_we`, exactly one of `w`/`h`/`b` high, `z` = `req_unsigned`, `addr` = `req_addr[ADDR_WIDTH-1:0]`, `data_in` = `req_wdata`.
  - If `ram_aerr` = 1, latch exc 10.
  - Store → RESP; load → CAPTURE.
- CAPTURE: all RAM controls low. Latch `ram_rdata` into `rsp_rdata` → RESP.
- RESP: `rsp_valid` = 1, all outputs held stable until `rsp_ready`. On handshake → IDLE.
- Outside ACCESS, `ram_ena`, `wena`, `w`, `h`, `b`, `z` = 0, and `addr`/`data_in` = 0.
- `req_ready` = 0 in every state except IDLE; one request is in flight at most.
- Reset (any state): FSM → IDLE; all outputs 0 except `req_ready` = 1; the in-flight request is dropped with no response. Because `ram_ena` falls asynchronously, a store whose ACCESS cycle is hit by reset before the clock edge does not commit.

## Timing
- Request accepted at edge E0.
- Load: ACCESS cycle E0–E1; RAM read registered at E1; CAPTURE E1–E2; `rsp_valid` high from E2. Latency 3 cycles.
- Store: ACCESS E0–E1; write commits at E1; `rsp_valid` from E1. Latency 2 cycles.
- Exception: `rsp_valid` from E0 (next cycle); RAM untouched.
- `rsp_ready` held low stalls in RESP indefinitely with no output change.
- Next request is accepted earliest the cycle after the response handshake. Best-case throughput: one load per 4 cycles.
- `rsp_ready` is ignored outside RESP.

## Structure
- Package `cpu55_mem_pkg`: size encodings (`SZ_BYTE`, `SZ_HALF`, `SZ_WORD`), exception codes (`EXC_NONE`, `EXC_ALIGN`, `EXC_RANGE`, `EXC_SIZE`), FSM state encoding. `data_ram` wrappers share these encodings.
- Sub-module `lsu_addr_check`: combinational size/alignment/range check producing the 2-bit exception code. Also reused by the instruction-fetch unit.

## Test plan
- Store word `0xffff0000` to addr 0, then load word addr 0 → `ram_ena`/`wena`/`w` high for exactly one cycle; load response `rsp_rdata` = `0xffff0000`, `rsp_exc` = 00, 3 cycles after accept.
- Store half `0x0000ffff` to addr 4, then load half addr 4 with `req_unsigned` = 1 → `rsp_rdata` = `0x0000ffff`. Same load with `req_unsigned` = 0 → `0xffffffff`.
- Load half addr 7 → `rsp_exc` = 01, `rsp_addr` = 7, `ram_ena` never asserted, `rsp_valid` one cycle after accept.
- Load word addr `0x00000800` (`ADDR_WIDTH` = 11) → `rsp_exc` = 10, no RAM access. Also: `req_size` = 11 → `rsp_exc` = 11.
- Hold `rsp_ready` = 0 for 5 cycles in RESP with `req_valid` = 1 → `req_ready` stays 0, response stable; the second request is accepted the cycle after the handshake.
- Assert `rst_n` = 0 mid-ACCESS of a store to addr 8 → `ram_ena` drops immediately, no response; a subsequent load of addr 8 returns the old contents.
